// File: rtl/vga_readback_if.sv
// rtl/vga_readback_if.sv - plot snoop, pixel read port and clear control bundle for vga_readback
interface vga_readback_if;
    logic        vga_plot;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [14:0] vga_color;
    logic        rd_req;
    logic [7:0]  rd_x;
    logic [6:0]  rd_y;
    logic        rd_busy;
    logic        rd_valid;
    logic [14:0] rd_color;
    logic        rd_error;
    logic        clear_start;
    logic        clear_busy;
    logic        plot_dropped;

    modport master (
        output vga_plot, vga_x, vga_y, vga_color,
        output rd_req, rd_x, rd_y, clear_start,
        input  rd_busy, rd_valid, rd_color, rd_error, clear_busy, plot_dropped
    );

    modport slave (
        input  vga_plot, vga_x, vga_y, vga_color,
        input  rd_req, rd_x, rd_y, clear_start,
        output rd_busy, rd_valid, rd_color, rd_error, clear_busy, plot_dropped
    );
endinterface

// File: rtl/vga_readback.sv
// rtl/vga_readback.sv - shadow framebuffer snooping VGA plots, with handshaked pixel readback and hardware clear
// Optional same-cycle plot forwarding into a read: define FLOW_VGA_READBACK_FORWARD_EN.
module vga_readback #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input logic           clock,
    input logic           reset,
    vga_readback_if.slave bus
);
    localparam int          DEPTH     = WIDTH * HEIGHT;
    localparam logic [7:0]  X_LIM     = 8'(WIDTH);
    localparam logic [6:0]  Y_LIM     = 7'(HEIGHT);
    localparam logic [14:0] LAST_ADDR = 15'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, ADDR, READ, RESP, CLEAR} state_t;
    state_t state, state_next;

    logic [14:0] mem [DEPTH];
    logic [7:0]  req_x;
    logic [6:0]  req_y;
    logic [14:0] rd_addr;
    logic        rd_in_range;
    logic [14:0] ram_q;
    logic [14:0] clr_cnt;
    logic [14:0] color_q;
    logic        error_q;
    logic        dropped_q;
    logic [14:0] plot_addr;
    logic        plot_in_range;
    logic        plot_we;
    logic        mem_we;
    logic [14:0] mem_waddr;
    logic [14:0] mem_wdata;
    logic [14:0] resp_color;

    function automatic logic [14:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
        return {8'd0, y} * 15'(WIDTH) + {7'd0, x};
    endfunction

    assign plot_addr     = pix_addr(bus.vga_x, bus.vga_y);
    assign plot_in_range = (bus.vga_x < X_LIM) && (bus.vga_y < Y_LIM);
    // The clear sweep owns the write port; reset suppresses any write in its cycle.
    assign plot_we   = bus.vga_plot && plot_in_range && (state != CLEAR) && !reset;
    assign mem_we    = ((state == CLEAR) || plot_we) && !reset;
    assign mem_waddr = (state == CLEAR) ? clr_cnt : plot_addr;
    assign mem_wdata = (state == CLEAR) ? 15'd0 : bus.vga_color;

    always_ff @(posedge clock) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
        if (state == READ && rd_in_range)
            ram_q <= mem[rd_addr];
    end

`ifdef FLOW_VGA_READBACK_FORWARD_EN
    logic        fwd_hit;
    logic [14:0] fwd_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            fwd_hit  <= 1'b0;
            fwd_data <= 15'd0;
        end else if (state == READ) begin
            fwd_hit  <= plot_we && (plot_addr == rd_addr);
            fwd_data <= bus.vga_color;
        end
    end

    assign resp_color = !rd_in_range ? 15'd0 : (fwd_hit ? fwd_data : ram_q);
`else
    assign resp_color = rd_in_range ? ram_q : 15'd0;
`endif

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.clear_start)
                    state_next = CLEAR;
                else if (bus.rd_req)
                    state_next = ADDR;
            end
            ADDR:  state_next = READ;
            READ:  state_next = RESP;
            RESP:  state_next = IDLE;
            CLEAR: if (clr_cnt == LAST_ADDR) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            req_x       <= 8'd0;
            req_y       <= 7'd0;
            rd_addr     <= 15'd0;
            rd_in_range <= 1'b0;
            clr_cnt     <= 15'd0;
            color_q     <= 15'd0;
            error_q     <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            dropped_q <= bus.vga_plot && (state == CLEAR);
            case (state)
                IDLE: begin
                    clr_cnt <= 15'd0;
                    if (!bus.clear_start && bus.rd_req) begin
                        req_x <= bus.rd_x;
                        req_y <= bus.rd_y;
                    end
                end
                ADDR: begin
                    rd_addr     <= pix_addr(req_x, req_y);
                    rd_in_range <= (req_x < X_LIM) && (req_y < Y_LIM);
                end
                RESP: begin
                    color_q <= resp_color;
                    error_q <= !rd_in_range;
                end
                CLEAR:   clr_cnt <= clr_cnt + 15'd1;
                default: ;
            endcase
        end
    end

    assign bus.rd_busy      = (state != IDLE);
    assign bus.clear_busy   = (state == CLEAR);
    assign bus.rd_valid     = (state == RESP);
    assign bus.rd_color     = (state == RESP) ? resp_color : color_q;
    assign bus.rd_error     = (state == RESP) ? !rd_in_range : error_q;
    assign bus.plot_dropped = dropped_q;
endmodule

// File: tb/tb_vga_readback.sv
// tb/tb_vga_readback.sv - directed self-checking bench for vga_readback
module tb_vga_readback;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    vga_readback_if bus();
    vga_readback #(.WIDTH(160), .HEIGHT(120)) dut (.clock(clock), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic plot(input logic [7:0] x, input logic [6:0] y, input logic [14:0] c);
        bus.vga_plot  = 1'b1;
        bus.vga_x     = x;
        bus.vga_y     = y;
        bus.vga_color = c;
        @(negedge clock);
        bus.vga_plot  = 1'b0;
    endtask

    task automatic read_px(input string tag, input logic [7:0] x, input logic [6:0] y,
                           input logic [14:0] exp_c, input logic exp_e);
        int lat;
        bus.rd_req = 1'b1;
        bus.rd_x   = x;
        bus.rd_y   = y;
        @(negedge clock);
        bus.rd_req = 1'b0;
        lat = 1;
        while (bus.rd_valid !== 1'b1 && lat < 8) begin
            @(negedge clock);
            lat++;
        end
        check({tag, "_latency"}, lat, 3);
        check({tag, "_color"}, bus.rd_color, exp_c);
        check({tag, "_error"}, bus.rd_error, exp_e);
        @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pulses;
        int cnt;
        logic [14:0] got_c;
        logic dropped_seen;

        reset = 1'b1;
        bus.vga_plot = 1'b0; bus.vga_x = '0; bus.vga_y = '0; bus.vga_color = '0;
        bus.rd_req = 1'b0; bus.rd_x = '0; bus.rd_y = '0; bus.clear_start = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_rd_busy", bus.rd_busy, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_rd_color", bus.rd_color, 0);
        check("rst_rd_error", bus.rd_error, 0);
        check("rst_clear_busy", bus.clear_busy, 0);
        check("rst_plot_dropped", bus.plot_dropped, 0);
        reset = 1'b0;
        @(negedge clock);

        plot(8'd10, 7'd5, 15'h7C00);
        read_px("rd_10_5", 8'd10, 7'd5, 15'h7C00, 1'b0);

        plot(8'd40, 7'd4, 15'h0155);
        plot(8'd200, 7'd3, 15'h1234);
        check("oor_plot_no_drop", bus.plot_dropped, 0);
        read_px("rd_40_4", 8'd40, 7'd4, 15'h0155, 1'b0);
        read_px("rd_160_0", 8'd160, 7'd0, 15'h0000, 1'b1);
        read_px("rd_0_120", 8'd0, 7'd120, 15'h0000, 1'b1);

        // Request held high while busy: only the first one is served.
        pulses = 0;
        got_c = '0;
        bus.rd_req = 1'b1; bus.rd_x = 8'd10; bus.rd_y = 7'd5;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            if (bus.rd_valid === 1'b1) begin
                pulses++;
                got_c = bus.rd_color;
            end
            if (i == 1) begin bus.rd_x = 8'd40; bus.rd_y = 7'd4; end
            if (i == 4) bus.rd_req = 1'b0;
        end
        check("busy_ignore_pulses", pulses, 1);
        check("busy_ignore_color", got_c, 15'h7C00);

        plot(8'd3, 7'd3, 15'h0011);
        bus.rd_req = 1'b1; bus.rd_x = 8'd3; bus.rd_y = 7'd3;
        @(negedge clock);
        bus.rd_req = 1'b0;
        @(negedge clock);
        bus.vga_plot = 1'b1; bus.vga_x = 8'd3; bus.vga_y = 7'd3; bus.vga_color = 15'h0022;
        @(negedge clock);
        bus.vga_plot = 1'b0;
        check("coll_valid", bus.rd_valid, 1);
`ifdef FLOW_VGA_READBACK_FORWARD_EN
        check("coll_color", bus.rd_color, 15'h0022);
`else
        check("coll_color", bus.rd_color, 15'h0011);
`endif
        @(negedge clock);
        read_px("coll_after", 8'd3, 7'd3, 15'h0022, 1'b0);

        read_px("pre_rst", 8'd10, 7'd5, 15'h7C00, 1'b0);
        bus.rd_req = 1'b1; bus.rd_x = 8'd40; bus.rd_y = 7'd4;
        @(negedge clock);
        bus.rd_req = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_addr_busy", bus.rd_busy, 0);
        check("rst_addr_color", bus.rd_color, 0);
        check("rst_addr_error", bus.rd_error, 0);
        pulses = 0;
        repeat (5) begin
            if (bus.rd_valid === 1'b1) pulses++;
            @(negedge clock);
        end
        check("rst_addr_no_valid", pulses, 0);

        plot(8'd0, 7'd0, 15'h03E0);
        plot(8'd159, 7'd119, 15'h03E0);
        plot(8'd2, 7'd0, 15'h0155);
        bus.clear_start = 1'b1;
        bus.rd_req = 1'b1; bus.rd_x = 8'd0; bus.rd_y = 7'd0;
        @(negedge clock);
        bus.clear_start = 1'b0;
        bus.rd_req = 1'b0;
        cnt = 0;
        pulses = 0;
        dropped_seen = 1'b0;
        while (bus.clear_busy === 1'b1 && cnt < 20000) begin
            cnt++;
            if (bus.rd_valid === 1'b1) pulses++;
            if (cnt == 10) begin
                bus.vga_plot = 1'b1; bus.vga_x = 8'd2; bus.vga_y = 7'd0; bus.vga_color = 15'h7FFF;
            end else if (cnt == 11) begin
                bus.vga_plot = 1'b0;
                dropped_seen = bus.plot_dropped;
            end
            @(negedge clock);
        end
        check("clear_cycles", cnt, 19200);
        repeat (3) begin
            if (bus.rd_valid === 1'b1) pulses++;
            @(negedge clock);
        end
        check("clear_lost_req", pulses, 0);
        check("clear_plot_dropped", dropped_seen, 1);
        read_px("clr_0_0", 8'd0, 7'd0, 15'h0000, 1'b0);
        read_px("clr_159_119", 8'd159, 7'd119, 15'h0000, 1'b0);
        read_px("clr_2_0", 8'd2, 7'd0, 15'h0000, 1'b0);

        plot(8'd99, 7'd0, 15'h0AAA);
        plot(8'd100, 7'd0, 15'h0AAA);
        bus.clear_start = 1'b1;
        @(negedge clock);
        bus.clear_start = 1'b0;
        repeat (100) @(negedge clock);
        check("rst_clr_busy_before", bus.clear_busy, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_clr_clear_busy", bus.clear_busy, 0);
        check("rst_clr_rd_busy", bus.rd_busy, 0);
        check("rst_clr_valid", bus.rd_valid, 0);
        check("rst_clr_dropped", bus.plot_dropped, 0);
        check("rst_clr_color", bus.rd_color, 0);
        read_px("rst_clr_addr99", 8'd99, 7'd0, 15'h0000, 1'b0);
        read_px("rst_clr_addr100", 8'd100, 7'd0, 15'h0AAA, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vga_readback.md
# vga_readback

Shadow framebuffer and pixel readback port for the flow VGA path. It snoops every plot the `flow` core issues to the VGA adapter (`vga_plot`/`vga_x`/`vga_y`/`vga_color`) into a 160x120x15 on-chip RAM. It gives the core a handshaked read port, the opposite direction of the plot stream, so programs can read pixels back. It also provides a hardware clear that matches the black background image.

## Interface
Parameters:
- `WIDTH`, 160, horizontal resolution in pixels
- `HEIGHT`, 120, vertical resolution in pixels

Ports:
- `clock`  in  1  system clock (CLOCK_50 domain)
- `reset`  in  1  synchronous, active-high reset
- `vga_plot`  in  1  snooped plot strobe; one write per cycle high
- `vga_x`  in  8  snooped plot x
- `vga_y`  in  7  snooped plot y
- `vga_color`  in  15  snooped plot colour, 5:5:5
- `rd_req`  in  1  read request; sampled only while `rd_busy`=0
- `rd_x`  in  8  read x, sampled with `rd_req`
- `rd_y`  in  7  read y, sampled with `rd_req`
- `rd_busy`  out  1  block not idle; `rd_req` ignored
- `rd_valid`  out  1  one-cycle pulse; `rd_color`/`rd_error` valid
- `rd_color`  out  15  read result, held until next `rd_valid`
- `rd_error`  out  1  last read out of range, held with `rd_color`
- `clear_start`  in  1  start full-frame clear to 0
- `clear_busy`  out  1  clear sweep in progress
- `plot_dropped`  out  1  one-cycle pulse: a plot was discarded

## Operation
- RAM: 19200 words x 15 bits, one write port, one read port. Synchronous read, 1-cycle latency. Not initialised by reset.
- Address rule: `addr = y*160 + x`, computed as `(y<<7)+(y<<5)+x` in 15 bits. In range iff `x<160 && y<120`.
- Plot snoop: in-range plots write `vga_color` at `addr` in the same cycle. Out-of-range plots are dropped silently, with no `plot_dropped`. Plots arriving while `clear_busy`=1 are dropped and pulse `plot_dropped`.
- FSM states: IDLE, ADDR, READ, RESP, CLEAR.
  - IDLE: `clear_start`=1 goes to CLEAR. This has priority over a simultaneous `rd_req`, which is lost. Otherwise `rd_req`=1 latches x/y and goes to ADDR.
  - ADDR: registers the address and the range flag, then goes to READ.
  - READ: issues the RAM read, then goes to RESP.
  - RESP: updates `rd_color` (RAM data, or 0 if out of range) and `rd_error`, pulses `rd_valid`, then goes to IDLE.
  - CLEAR: a 15-bit counter writes 0 to addresses 0..19199, one per cycle. After writing 19199 it goes to IDLE.
- `rd_busy` = (state != IDLE). `clear_busy` = (state == CLEAR).
- `clear_start` outside IDLE is ignored.
- Plot versus clear write in the same cycle: the clear write owns the port and the plot is dropped.

## Timing
- Reset values: `rd_busy`=0, `rd_valid`=0, `rd_color`=0, `rd_error`=0, `clear_busy`=0, `plot_dropped`=0. State is IDLE and the clear counter is 0.
- Read latency: `rd_req` accepted at edge T gives `rd_valid`=1 in cycle T+3. `rd_busy`=1 in cycles T+1..T+3. The next request can be accepted at edge T+4. Throughput is 1 read per 4 cycles.
- Plot visibility: a plot written in or before the ADDR cycle is visible to the read. A plot in the READ cycle to the same address is a collision; see Configuration. Plots after READ are not visible.
- Clear: `clear_start` at edge T gives `clear_busy`=1 for cycles T+1..T+19200 and IDLE at T+19201. Address k is written in cycle T+1+k.
- Reset mid-read: no `rd_valid` is issued. Reset mid-clear aborts the clear, leaving RAM partially cleared. Both take effect at the next edge.
- `plot_dropped` is registered and asserts the cycle after the dropped plot.

## Configuration
- `FLOW_VGA_READBACK_FORWARD_EN` defined: a same-address plot in the READ cycle is forwarded. `rd_color` returns the new `vga_color` (write-first).
- Not defined: no forwarding logic. `rd_color` returns the pre-write RAM value (read-first), and the write still lands in RAM.

## Test plan
- Plot (10,5) colour 0x7C00, then read (10,5) → `rd_valid` exactly 3 cycles after the request; `rd_color`=0x7C00, `rd_error`=0.
- Read (160,0) and (0,120) → `rd_color`=0, `rd_error`=1; an out-of-range plot of 0x1234 to (200,3) leaves address 3*160+200-relative pixels unchanged, e.g. (40,4) still reads its prior value.
- Fill (0,0) and (159,119) with 0x03E0, then clear → `clear_busy` high for exactly 19200 cycles; both pixels read 0; a plot during the clear pulses `plot_dropped` and is not stored.
- `clear_start` and `rd_req` in the same IDLE cycle → clear runs and no `rd_valid` occurs. `rd_req` while `rd_busy`=1 → ignored, exactly one `rd_valid` pulse.
- Collision: (3,3)=0x0011, read (3,3) with a plot of 0x0022 to (3,3) in the READ cycle → `rd_color`=0x0022 with the macro, 0x0011 without. The next read returns 0x0022 in both builds.
- Reset asserted during ADDR and during CLEAR (k=100) → no `rd_valid`, all outputs 0. Address 99 reads 0 and address 100 keeps its prior value.
